// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with valid tracking, stall, flush and
// an optional two-entry skid buffer. The payload is opaque to this block.
module pipe_stage_reg #(
  parameter int DATA_W       = 75,
  parameter int SKID         = 1,
  parameter int CLR_ON_FLUSH = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [1:0]        occ_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Main entry drives the output; skid entry catches the one payload that
  // arrives while main is stalled (only used when SKID != 0).
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [1:0]        occ_q,        occ_d;

  logic in_ready;
  logic in_xfer;
  logic out_xfer;

  // With a skid buffer the ready is purely a flop output, so the downstream
  // ready never reaches upstream combinationally. Without it, ready looks
  // through to the downstream handshake.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = !skid_valid_q;
    end else begin : g_comb_ready
      assign in_ready = !main_valid_q | out_ready_i;
    end
  endgenerate

  assign in_xfer  = in_valid_i & in_ready;
  assign out_xfer = main_valid_q & out_ready_i;

  // Next-state: drain, refill from skid or input, flush, stall counting.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    stall_cnt_d  = stall_cnt_q;

    // Drain the main entry; the skid entry (if any) takes its place so
    // FIFO order is kept.
    if (out_xfer) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // Accept: main if it is empty or draining now, otherwise park in skid.
    // in_ready is low while skid is full, so skid is never overwritten.
    if (in_xfer) begin
      if (!main_valid_q || out_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data_i;
      end else if (SKID != 0) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end

    // Flush kills everything held, including a same-cycle input. An output
    // transfer on this edge has already been seen downstream.
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLR_ON_FLUSH != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end

    // Saturating count of stalled cycles; flush does not clear it.
    if (main_valid_q && !out_ready_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  // State registers; reset wins over flush and any transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
      occ_q        <= 2'd0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
      occ_q        <= occ_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign stall_cnt_o = stall_cnt_q;
  assign occ_o       = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances share one stimulus stream
// (0: SKID=1, 1: SKID=0, 2: SKID=1 with CNT_W=4 and payload clear on flush).
// Each instance is compared every cycle against a queue-style reference,
// plus a directed vector table and short hand-written corner sequences.
module tb_pipe_stage_reg;

  localparam int DW = 75;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          rdy [3];
  logic          ov  [3];
  logic [DW-1:0] od  [3];
  logic [1:0]    occ [3];
  logic [15:0]   sc0, sc1;
  logic [3:0]    sc2;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CLR_ON_FLUSH(0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy[0]), .in_data_i(in_data), .out_valid_o(ov[0]),
    .out_ready_i(out_ready), .out_data_o(od[0]), .stall_cnt_o(sc0), .occ_o(occ[0]));

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CLR_ON_FLUSH(0), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy[1]), .in_data_i(in_data), .out_valid_o(ov[1]),
    .out_ready_i(out_ready), .out_data_o(od[1]), .stall_cnt_o(sc1), .occ_o(occ[1]));

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CLR_ON_FLUSH(1), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy[2]), .in_data_i(in_data), .out_valid_o(ov[2]),
    .out_ready_i(out_ready), .out_data_o(od[2]), .stall_cnt_o(sc2), .occ_o(occ[2]));

  // Reference: an ordered list of held payloads per instance, its capacity,
  // a saturating stall tally, and whether the visible payload is known zero.
  int            m_n   [3];
  logic [DW-1:0] m_e   [3][2];
  int            m_cnt [3];
  bit            m_clr [3];
  bit            m_on = 1'b0;

  function automatic bit has_skid(int i); return i != 1; endfunction
  function automatic bit clr_fl(int i);   return i == 2; endfunction
  function automatic int cnt_max(int i);  return (i == 2) ? 15 : 65535; endfunction

  function automatic bit m_ready(int i);
    if (has_skid(i)) return m_n[i] < 2;
    return (m_n[i] == 0) || out_ready;
  endfunction

  function automatic logic [15:0] stall_of(int i);
    case (i)
      0:       return sc0;
      1:       return sc1;
      default: return {12'd0, sc2};
    endcase
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs and stop at the falling edge for sampling.
  task automatic apply(input bit r, input bit f, input bit iv, input logic [DW-1:0] d, input bit ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge clk);
  endtask

  // Compare every instance with the reference, advance the reference by the
  // transfer rules, then let the rising edge happen.
  task automatic advance();
    for (int i = 0; i < 3; i++) begin
      if (m_on) begin
        chk($sformatf("m%0d_ready", i), DW'(rdy[i]), DW'(m_ready(i)));
        chk($sformatf("m%0d_valid", i), DW'(ov[i]), DW'(m_n[i] > 0));
        chk($sformatf("m%0d_occ", i), DW'(occ[i]), DW'(m_n[i]));
        chk($sformatf("m%0d_stall", i), DW'(stall_of(i)), DW'(m_cnt[i]));
        if (m_n[i] > 0)
          chk($sformatf("m%0d_data", i), od[i], m_e[i][0]);
        else if (m_clr[i])
          chk($sformatf("m%0d_zero", i), od[i], '0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_n[i] = 0; m_cnt[i] = 0; m_clr[i] = 1'b1;
      end else if (m_on) begin
        bit ix, ox;
        ix = in_valid && m_ready(i);
        ox = (m_n[i] > 0) && out_ready;
        if ((m_n[i] > 0) && !out_ready && (m_cnt[i] < cnt_max(i))) m_cnt[i]++;
        if (ox) begin
          m_e[i][0] = m_e[i][1];
          m_n[i]--;
          m_clr[i] = 1'b0;
        end
        if (flush) begin
          m_n[i] = 0;
          if (clr_fl(i)) m_clr[i] = 1'b1;
        end else if (ix) begin
          m_e[i][m_n[i]] = in_data;
          m_n[i]++;
          m_clr[i] = 1'b0;
        end
      end
    end
    if (rst) m_on = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r, f, iv; logic [7:0] d; bit ordy;
    bit chk, chkd, ev; logic [7:0] ed; logic [1:0] eo; bit er; int es;
  } vec_t;

  function automatic vec_t vr(bit r, bit f, bit iv, logic [7:0] d, bit ordy,
                              bit c, bit cd, bit ev, logic [7:0] ed,
                              logic [1:0] eo, bit er, int es);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.chk = c; v.chkd = cd; v.ev = ev; v.ed = ed; v.eo = eo; v.er = er; v.es = es;
    return v;
  endfunction

  vec_t tbl [25];

  initial begin
    // Expectations are for instance 0, observed before the edge of that row.
    //            r  f  iv d      or  chk cd ev ed     eo er es
    tbl[0]  = vr(1, 0, 0, 8'h00, 1,  0, 0, 0, 8'h00, 0, 0, 0);
    tbl[1]  = vr(0, 0, 0, 8'h00, 1,  1, 1, 0, 8'h00, 0, 1, 0);
    tbl[2]  = vr(0, 0, 1, 8'h01, 1,  1, 0, 0, 8'h00, 0, 1, 0);
    tbl[3]  = vr(0, 0, 1, 8'h02, 1,  1, 0, 1, 8'h01, 1, 1, 0);
    tbl[4]  = vr(0, 0, 1, 8'h03, 1,  1, 0, 1, 8'h02, 1, 1, 0);
    tbl[5]  = vr(0, 0, 1, 8'h04, 1,  1, 0, 1, 8'h03, 1, 1, 0);
    tbl[6]  = vr(0, 0, 0, 8'h00, 1,  1, 0, 1, 8'h04, 1, 1, 0);
    tbl[7]  = vr(0, 0, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0, 1, 0);
    tbl[8]  = vr(0, 0, 1, 8'h0A, 0,  1, 0, 0, 8'h00, 0, 1, 0);
    tbl[9]  = vr(0, 0, 1, 8'h0B, 0,  1, 0, 1, 8'h0A, 1, 1, 0);
    tbl[10] = vr(0, 0, 1, 8'h0C, 0,  1, 0, 1, 8'h0A, 2, 0, 1);
    tbl[11] = vr(0, 0, 1, 8'h0C, 0,  1, 0, 1, 8'h0A, 2, 0, 2);
    tbl[12] = vr(0, 0, 1, 8'h0C, 1,  1, 0, 1, 8'h0A, 2, 0, 3);
    tbl[13] = vr(0, 0, 1, 8'h0C, 1,  1, 0, 1, 8'h0B, 1, 1, 3);
    tbl[14] = vr(0, 0, 0, 8'h00, 1,  1, 0, 1, 8'h0C, 1, 1, 3);
    tbl[15] = vr(0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 1, 3);
    tbl[16] = vr(0, 0, 1, 8'h21, 0,  1, 0, 0, 8'h00, 0, 1, 3);
    tbl[17] = vr(0, 0, 1, 8'h22, 0,  1, 0, 1, 8'h21, 1, 1, 3);
    tbl[18] = vr(0, 1, 1, 8'h0D, 1,  1, 0, 1, 8'h21, 2, 0, 4);
    tbl[19] = vr(0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 1, 4);
    tbl[20] = vr(0, 0, 0, 8'h00, 1,  1, 0, 0, 8'h00, 0, 1, 4);
    tbl[21] = vr(0, 0, 1, 8'h31, 0,  1, 0, 0, 8'h00, 0, 1, 4);
    tbl[22] = vr(0, 0, 1, 8'h32, 0,  1, 0, 1, 8'h31, 1, 1, 4);
    tbl[23] = vr(1, 1, 1, 8'h33, 0,  1, 0, 1, 8'h31, 2, 0, 5);
    tbl[24] = vr(0, 0, 0, 8'h00, 0,  1, 1, 0, 8'h00, 0, 1, 0);

    for (int k = 0; k < 25; k++) begin
      apply(tbl[k].r, tbl[k].f, tbl[k].iv, DW'(tbl[k].d), tbl[k].ordy);
      if (tbl[k].chk) begin
        chk($sformatf("t%0d_valid", k), DW'(ov[0]), DW'(tbl[k].ev));
        chk($sformatf("t%0d_occ", k), DW'(occ[0]), DW'(tbl[k].eo));
        chk($sformatf("t%0d_ready", k), DW'(rdy[0]), DW'(tbl[k].er));
        chk($sformatf("t%0d_stall", k), DW'(sc0), DW'(tbl[k].es));
        if (tbl[k].ev || tbl[k].chkd)
          chk($sformatf("t%0d_data", k), od[0], DW'(tbl[k].ed));
      end
      advance();
    end

    // Single-entry stage: reload on simultaneous in/out transfer.
    apply(0, 0, 1, DW'(8'h11), 0);
    advance();
    apply(0, 0, 1, DW'(8'h22), 1);
    chk("s0_ready_comb", DW'(rdy[1]), DW'(1));
    chk("s0_hold_11", od[1], DW'(8'h11));
    advance();
    apply(0, 0, 1, DW'(8'h33), 0);
    chk("s0_valid_22", DW'(ov[1]), DW'(1));
    chk("s0_data_22", od[1], DW'(8'h22));
    chk("s0_not_ready", DW'(rdy[1]), DW'(0));
    advance();

    // Saturation of the 4-bit counter over a 20-cycle stall.
    apply(1, 0, 0, '0, 0);
    advance();
    apply(0, 0, 1, DW'(8'h05), 0);
    advance();
    for (int k = 0; k < 20; k++) begin
      apply(0, 0, 0, '0, 0);
      advance();
    end
    apply(0, 0, 0, '0, 0);
    chk("sat_cnt4", DW'(sc2), DW'(15));
    chk("sat_cnt16", DW'(sc0), DW'(20));
    advance();

    // Flush on the clearing instance must zero the visible payload.
    apply(0, 1, 0, '0, 0);
    advance();
    apply(0, 0, 0, '0, 0);
    chk("clr_flush_data", od[2], '0);
    chk("clr_flush_cnt", DW'(sc2), DW'(15));
    advance();

    // Randomised traffic against the reference for all instances.
    for (int k = 0; k < 400; k++) begin
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1,
            DW'({$urandom, $urandom, $urandom}),
            $urandom_range(0, 9) < 7);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register. It replaces the hand-written, free-running inter-stage registers (EXE→MEM and the others) in the 5-stage core.
- Adds per-stage valid tracking, back-pressure (stall), synchronous flush, and an optional 2-entry skid buffer that removes the combinational ready path between stages.
- The payload is an opaque concatenated bus; the instantiating stage packs and unpacks its fields.

Parameters:
- DATA_W, 75, payload width in bits (default = EXE/MEM bundle: 32+5+1+32+1+1+3).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.
- CLR_ON_FLUSH, 0, 1 = zero stored payload on flush/reset-invalidate; 0 = payload held, only valid cleared.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  kill all held entries (branch mispredict/trap).
- in_valid_i  in  1  upstream has a payload.
- in_ready_o  out  1  stage can accept a payload this cycle.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  out_data_o is a live instruction.
- out_ready_i  in  1  downstream accepts this cycle.
- out_data_o  out  DATA_W  payload to downstream.
- stall_cnt_o  out  CNT_W  saturating count of cycles with out_valid_o=1 and out_ready_i=0.
- occ_o  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Transfer rules: an input transfer occurs when in_valid_i & in_ready_o; an output transfer occurs when out_valid_o & out_ready_i.
- Reset (rst_i=1 at an edge):
  - all entry valids=0, out_data_o=0, stall_cnt_o=0, occ_o=0;
  - in_ready_o=1 from the following cycle.
  - Reset overrides flush and any transfer, including mid-stall.
- Latency: 1 cycle. A payload accepted at edge N is on out_data_o with out_valid_o=1 after edge N.
- SKID=0:
  - in_ready_o = !out_valid_o | out_ready_i (combinational).
  - On input transfer the entry loads in_data_i.
  - On output transfer without input transfer, valid clears.
  - Simultaneous in/out transfer: the entry reloads and valid stays 1.
- SKID=1:
  - Entries are main (drives out_data_o) and skid.
  - in_ready_o = !skid_valid (registered, no path from out_ready_i).
  - Input arrives with main empty, or with main draining this cycle → load main.
  - Input arrives with main full and not draining → load skid.
  - Output transfer with skid valid → skid moves to main; skid clears unless refilled the same cycle (cannot happen: in_ready_o=0 while skid valid).
  - FIFO order is always preserved. No payload is dropped or duplicated.
- Flush (flush_i=1, rst_i=0):
  - at the edge, main and skid valids clear; any input transfer that cycle is discarded;
  - out_valid_o=0 and occ_o=0 next cycle;
  - payload zeroed only if CLR_ON_FLUSH=1;
  - in_ready_o=1 next cycle.
  - An output transfer coinciding with flush completes (downstream already sampled it).
- Stall counter: increments at each edge where out_valid_o=1 and out_ready_i=0, and saturates at 2^CNT_W-1. Cleared only by reset, not by flush.
- occ_o = main_valid + skid_valid, registered.
- X-safety: out_data_o content is don't-care when out_valid_o=0. Consumers must gate side effects (rd_we, mem_we) with out_valid_o.
- Illegal input: in_valid_i with in_ready_o=0 is not a transfer; data is ignored, and upstream must hold.

Test Plan:
- Streaming, SKID=1:
  - Stimulus: out_ready_i=1; in_data_i=1,2,3,4 on consecutive cycles.
  - Required: out_data_o=1,2,3,4 one cycle later, back-to-back; in_ready_o stays 1; occ_o=1; stall_cnt_o=0.
- Back-pressure, SKID=1:
  - Stimulus: send 0xA, 0xB while out_ready_i=0 for 3 cycles, then release.
  - Required: occ_o=2 and in_ready_o=0 after the second accept; 0xC is held upstream; outputs are 0xA, 0xB, 0xC in order; stall_cnt_o=3.
- Flush mid-stall:
  - Stimulus: two entries held; flush_i=1 with in_valid_i=1 and data 0xD.
  - Required: next cycle out_valid_o=0, occ_o=0, in_ready_o=1; 0xD is never emitted; stall_cnt_o is unchanged.
- Reset mid-operation:
  - Stimulus: occ_o=2 and stall_cnt_o=5; assert rst_i together with flush_i and in_valid_i.
  - Required: next cycle out_valid_o=0, out_data_o=0, stall_cnt_o=0, occ_o=0.
- SKID=0 simultaneous transfer:
  - Stimulus: entry holds 0x11; out_ready_i=1; in_valid_i=1 with 0x22.
  - Required: in_ready_o=1 combinationally; next cycle out_data_o=0x22 and out_valid_o=1.
- Counter saturation:
  - Stimulus: CNT_W=4; hold out_valid_o=1 and out_ready_i=0 for 20 cycles.
  - Required: stall_cnt_o stops at 15.
